ntt_idx_fsm_param: RTL and testbench

- Parametrised index/control sequencer for the radix-2 multi-BFU NTT datapath.
- Generates the (stage p, group k, offset i) tuple each cycle for forward NTT, inverse NTT and point-wise multiply (PWM), for any power-of-two length and BFU count.
- Produces read, twiddle-ROM, BFU-enable and write strobes aligned to configurable pipeline latencies.
- Adds a start/busy/done handshake, stall support and a drain phase.

---
 rtl/ntt_idx_fsm_param.sv | 159 +++++++++++++++
 tb/tb_ntt_idx_fsm_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_idx_fsm_param.sv
// Index sequencer for a radix-2 multi-BFU NTT datapath: walks (p,k,i) for NTT, INTT and PWM
// and emits read/twiddle issue plus BFU-enable and write strobes delayed to the datapath latency.
module ntt_idx_fsm_param #(
    parameter  int N_LOG   = 10,
    parameter  int BFU_LOG = 2,
    parameter  int EN_LAT  = 7,
    parameter  int WEN_LAT = 8,
    localparam int CW      = N_LOG - 1 - BFU_LOG,
    localparam int PW      = $clog2(N_LOG)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [1:0]    i_mode,
    input  logic          i_stall,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic          o_issue,
    output logic          o_sel,
    output logic [PW-1:0] o_p,
    output logic [CW-1:0] o_k,
    output logic [CW-1:0] o_i,
    output logic          o_en,
    output logic          o_wen
);

    // state   | meaning
    // S_IDLE  | waiting for start; mode=3 start raises err
    // S_RUN   | one tuple per unstalled cycle
    // S_DRAIN | no issue; wait for the write strobe pipeline to empty

    localparam logic [1:0]    MODE_NTT  = 2'd0;
    localparam logic [1:0]    MODE_INTT = 2'd1;
    localparam logic [1:0]    MODE_PWM  = 2'd2;
    localparam logic [1:0]    MODE_BAD  = 2'd3;
    localparam logic [PW-1:0] P_TOP     = PW'(N_LOG - 1);
    localparam logic [PW-1:0] P_BFU     = PW'(BFU_LOG);
    localparam logic [CW-1:0] ONES      = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_mode;
    logic [PW-1:0]      r_p;
    logic [CW-1:0]      r_k;
    logic [CW-1:0]      r_i;
    logic [WEN_LAT-1:0] r_dl;
    logic               r_done;
    logic               r_err;

    logic               w_accept;
    logic               w_bad_start;
    logic               w_issue;
    logic               w_wide;
    logic               w_stage_end;
    logic               w_last;
    logic               w_dl_tail_empty;
    logic [PW-1:0]      w_i_sh;
    logic [PW-1:0]      w_k_sh;
    logic [CW-1:0]      w_i_max;
    logic [CW-1:0]      w_k_max;

    // Wide stages split C issues into (N/2>>p) groups of (2^p>>BFU_LOG) offsets; the
    // limits are all-ones masks, so a shift by CW yields C-1 without overflow.
    assign w_wide      = (r_mode != MODE_PWM) && (r_p >= P_BFU);
    assign w_i_sh      = r_p - P_BFU;
    assign w_k_sh      = P_TOP - r_p;
    assign w_i_max     = w_wide ? ~(ONES << w_i_sh) : '0;
    assign w_k_max     = w_wide ? ~(ONES << w_k_sh) : ONES;
    assign w_stage_end = (r_i == w_i_max) && (r_k == w_k_max);
    assign w_last      = w_stage_end && ((r_mode == MODE_INTT) ? (r_p == P_TOP) : (r_p == '0));

    // Everything below the wen tap is empty: the current wen (if any) is the final one.
    assign w_dl_tail_empty = ((r_dl << 1) == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_accept    = 1'b0;
        w_bad_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_mode == MODE_BAD) begin
                        w_bad_start = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_issue = !i_stall;
                if (w_issue && w_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_dl_tail_empty) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode <= MODE_NTT;
            r_p    <= '0;
            r_k    <= '0;
            r_i    <= '0;
            r_dl   <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_dl   <= (r_dl << 1) | WEN_LAT'(w_issue);
            r_done <= (r_state == S_DRAIN) && w_dl_tail_empty;
            r_err  <= w_bad_start;
            if (w_accept) begin
                r_mode <= i_mode;
                r_p    <= (i_mode == MODE_NTT) ? P_TOP : '0;
                r_k    <= '0;
                r_i    <= '0;
            end else if (w_issue) begin
                if (w_last) begin
                    r_p <= '0;
                    r_k <= '0;
                    r_i <= '0;
                end else if (r_i != w_i_max) begin
                    r_i <= r_i + 1'b1;
                end else begin
                    r_i <= '0;
                    if (r_k != w_k_max) begin
                        r_k <= r_k + 1'b1;
                    end else begin
                        r_k <= '0;
                        r_p <= (r_mode == MODE_INTT) ? r_p + 1'b1 : r_p - 1'b1;
                    end
                end
            end
        end
    end

    assign o_busy  = (r_state != S_IDLE);
    assign o_done  = r_done;
    assign o_err   = r_err;
    assign o_issue = w_issue;
    assign o_sel   = (r_mode == MODE_INTT);
    assign o_p     = r_p;
    assign o_k     = r_k;
    assign o_i     = r_i;
    assign o_en    = r_dl[EN_LAT-1];
    assign o_wen   = r_dl[WEN_LAT-1];

endmodule

// File: tb/tb_ntt_idx_fsm_param.sv
// Bench for ntt_idx_fsm_param: handshake vector table, then full runs on a default build and an
// N_LOG=8/BFU_LOG=1 build, checked each cycle against a tuple-list reference model.
module tb_ntt_idx_fsm_param;

    logic       clk = 1'b0;
    logic       rst, start_a, start_b, stall;
    logic [1:0] mode;
    bit         use_b;

    logic       a_busy, a_done, a_err, a_issue, a_sel, a_en, a_wen;
    logic [3:0] a_p;
    logic [6:0] a_k, a_i;
    logic       b_busy, b_done, b_err, b_issue, b_sel, b_en, b_wen;
    logic [2:0] b_p;
    logic [5:0] b_k, b_i;

    int n_tests = 0;
    int n_fail  = 0;
    bit hist [0:8191];

    always #5 clk = ~clk;

    ntt_idx_fsm_param u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_mode(mode), .i_stall(stall),
        .o_busy(a_busy), .o_done(a_done), .o_err(a_err), .o_issue(a_issue), .o_sel(a_sel),
        .o_p(a_p), .o_k(a_k), .o_i(a_i), .o_en(a_en), .o_wen(a_wen)
    );

    ntt_idx_fsm_param #(.N_LOG(8), .BFU_LOG(1), .EN_LAT(7), .WEN_LAT(8)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_mode(mode), .i_stall(stall),
        .o_busy(b_busy), .o_done(b_done), .o_err(b_err), .o_issue(b_issue), .o_sel(b_sel),
        .o_p(b_p), .o_k(b_k), .o_i(b_i), .o_en(b_en), .o_wen(b_wen)
    );

    // {busy,done,err,issue,sel,en,wen,p,k,i}
    logic [30:0] obs;
    always_comb begin
        obs = '0;
        if (use_b) obs = {b_busy, b_done, b_err, b_issue, b_sel, b_en, b_wen, 8'(b_p), 8'(b_k), 8'(b_i)};
        else       obs = {a_busy, a_done, a_err, a_issue, a_sel, a_en, a_wen, 8'(a_p), 8'(a_k), 8'(a_i)};
    end

    function automatic logic [30:0] mkv(input bit busy, done, err, issue, sel, en, wen,
                                        input int p, k, i);
        return {busy, done, err, issue, sel, en, wen, 8'(p), 8'(k), 8'(i)};
    endfunction

    task automatic chk(input string name, input logic [30:0] got, input logic [30:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (busy,done,err,issue,sel,en,wen|p|k|i)", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One complete job: start at cycle 0, optional fixed stall window, random stalls,
    // a start attempt while busy, an optional reset, and an expected done cycle (0 = don't care).
    task automatic run_seq(input bit b, input int md, input int st_at, input int st_len,
                           input int rnd_pct, input int bs_at, input int rst_at, input int exp_done);
        int nl, bl, el, wl, stages, cc, idx, last, done_obs;
        bit st_now, exp_issue, exp_en, exp_wen, exp_dn, exp_busy, fin;
        logic [23:0] tq[$];
        logic [23:0] tup;
        string tag;
        nl = b ? 8 : 10;
        bl = b ? 1 : 2;
        el = 7;
        wl = 8;
        cc = 1 << (nl - 1 - bl);
        stages = (md == 2) ? 1 : nl;
        tq.delete();
        for (int s = 0; s < stages; s++) begin
            int p;
            p = (md == 0) ? nl - 1 - s : (md == 1) ? s : 0;
            if (md != 2 && (1 << p) >= (1 << bl)) begin
                for (int k = 0; k < ((1 << (nl - 1)) >> p); k++)
                    for (int i = 0; i < ((1 << p) >> bl); i++)
                        tq.push_back({8'(p), 8'(k), 8'(i)});
            end else begin
                for (int k = 0; k < cc; k++) tq.push_back({8'(p), 8'(k), 8'd0});
            end
        end
        for (int c = 0; c < 8192; c++) hist[c] = 1'b0;
        tag = $sformatf("%s m%0d", b ? "B" : "A", md);

        @(posedge clk); #1;
        use_b = b;
        mode  = 2'(md);
        stall = 1'b0;
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);

        idx = 0; last = -1; done_obs = -1; fin = 1'b0;
        for (int c = 1; c < 8000; c++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            start_b = 1'b0;
            mode    = 2'(md);
            if (c == bs_at) begin
                if (b) start_b = 1'b1; else start_a = 1'b1;
                mode = 2'($urandom_range(3, 0));
            end
            st_now = (c >= st_at && c < st_at + st_len && st_at >= 0) ||
                     ($urandom_range(99, 0) < rnd_pct);
            stall = st_now;
            rst   = (c == rst_at);
            @(negedge clk);
            if (c == rst_at + 1) begin
                chk({tag, " after reset"}, obs, mkv(0,0,0,0,0,0,0, 0,0,0));
                fin = 1'b1;
                break;
            end
            exp_issue = (idx < tq.size()) && !st_now;
            tup       = (idx < tq.size()) ? tq[idx] : 24'd0;
            hist[c]   = exp_issue;
            if (exp_issue) begin
                idx++;
                if (idx == tq.size()) last = c;
            end
            exp_en   = (c - el >= 1) && hist[c - el];
            exp_wen  = (c - wl >= 1) && hist[c - wl];
            exp_dn   = (last > 0) && (c == last + wl + 1);
            exp_busy = !((last > 0) && (c >= last + wl + 1));
            chk($sformatf("%s c=%0d", tag, c), obs,
                {exp_busy, exp_dn, 1'b0, exp_issue, (md == 1), exp_en, exp_wen, tup});
            if (obs[29] && done_obs < 0) done_obs = c;
            if (last > 0 && c == last + wl + 2) begin
                fin = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!fin) begin
            n_fail++;
            $display("FAIL %s timeout: got no completion expected completion", tag);
        end
        if (exp_done > 0) chk_int({tag, " done cycle"}, done_obs, exp_done);
        rst   = 1'b0;
        stall = 1'b0;
    endtask

    typedef struct {
        bit         rst;
        bit         start;
        logic [1:0] mode;
        bit         stall;
        bit         busy;
        bit         err;
        bit         issue;
        bit         sel;
        int         p;
        int         k;
        int         i;
    } vec_t;

    vec_t tbl [13];

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode = 2'd0; stall = 1'b0; use_b = 1'b0;
        // rst start mode stall | busy err issue sel | p k i   (default build, INTT p=0 => k counts)
        tbl[0]  = '{0, 0, 2'd0, 0,  0, 0, 0, 0,  0, 0, 0};
        tbl[1]  = '{0, 1, 2'd3, 0,  0, 0, 0, 0,  0, 0, 0};
        tbl[2]  = '{0, 0, 2'd0, 0,  0, 1, 0, 0,  0, 0, 0};
        tbl[3]  = '{0, 0, 2'd0, 1,  0, 0, 0, 0,  0, 0, 0};
        tbl[4]  = '{0, 1, 2'd1, 0,  0, 0, 0, 0,  0, 0, 0};
        tbl[5]  = '{0, 0, 2'd0, 1,  1, 0, 0, 1,  0, 0, 0};
        tbl[6]  = '{0, 0, 2'd0, 0,  1, 0, 1, 1,  0, 0, 0};
        tbl[7]  = '{0, 0, 2'd0, 0,  1, 0, 1, 1,  0, 1, 0};
        tbl[8]  = '{0, 1, 2'd0, 0,  1, 0, 1, 1,  0, 2, 0};
        tbl[9]  = '{0, 0, 2'd0, 1,  1, 0, 0, 1,  0, 3, 0};
        tbl[10] = '{0, 0, 2'd0, 0,  1, 0, 1, 1,  0, 3, 0};
        tbl[11] = '{1, 0, 2'd0, 1,  1, 0, 0, 1,  0, 4, 0};
        tbl[12] = '{0, 0, 2'd0, 0,  0, 0, 0, 0,  0, 0, 0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        use_b = 1'b1;
        #1 chk("reset B", obs, mkv(0,0,0,0,0,0,0, 0,0,0));
        use_b = 1'b0;

        for (int r = 0; r < 13; r++) begin
            @(posedge clk); #1;
            rst     = tbl[r].rst;
            start_a = tbl[r].start;
            mode    = tbl[r].mode;
            stall   = tbl[r].stall;
            @(negedge clk);
            chk($sformatf("vec%0d", r), obs,
                mkv(tbl[r].busy, 0, tbl[r].err, tbl[r].issue, tbl[r].sel, 0, 0,
                    tbl[r].p, tbl[r].k, tbl[r].i));
        end
        @(posedge clk); #1;
        rst = 1'b0; start_a = 1'b0; stall = 1'b0;

        run_seq(0, 0, -1, 0, 0, -1, -1, 1289);
        run_seq(0, 1, -1, 0, 0, 500, -1, 1289);
        run_seq(0, 2, -1, 0, 0, -1, -1, 137);
        run_seq(0, 0, 300, 5, 0, -1, -1, 1294);
        run_seq(0, 0, -1, 0, 0, -1, 600, 0);
        run_seq(0, 0, -1, 0, 0, -1, -1, 1289);
        for (int m = 0; m < 3; m++) run_seq(0, m, -1, 0, 25, $urandom_range(500, 2), -1, 0);

        run_seq(1, 0, -1, 0, 0, 100, -1, 521);
        run_seq(1, 1, -1, 0, 0, -1, -1, 521);
        run_seq(1, 2, -1, 0, 0, 30, -1, 73);
        for (int m = 0; m < 3; m++) run_seq(1, m, 40, 3, 20, $urandom_range(300, 2), -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
